// File: rtl/mac_acc_sequencer_if.sv
// Job/term/result handshake bundle for mac_acc_sequencer.
// master = job source and result sink, slave = the sequencer.
interface mac_acc_sequencer_if #(
    parameter int ACC_W = 32,
    parameter int IN_W  = 16,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic [ACC_W-1:0] init_val;
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             in_ready;
    logic             out_valid;
    logic [ACC_W-1:0] out_data;
    logic             out_ready;
    logic             busy;
    logic             ovf;

    modport master (
        output start, len, init_val, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, ovf
    );
    modport slave (
        input  start, len, init_val, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, ovf
    );
endinterface

// File: rtl/mac_acc_sequencer.sv
// Single-job MAC accumulation sequencer: preload, accumulate accepted beats, present sum.
// Build option MAC_SEQ_SATURATE_EN: clamp the accumulator on signed overflow instead of wrapping.
module mac_acc_sequencer #(
    parameter int ACC_W = 32,
    parameter int IN_W  = 16,
    parameter int CNT_W = 8
) (
    input logic                 clk,
    input logic                 reset,
    mac_acc_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] term_ext;
    logic [ACC_W:0]   sum;
    logic             sum_ovf;
    logic [ACC_W-1:0] next_acc;

    assign term_ext = {{(ACC_W-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
    assign sum      = {acc_q[ACC_W-1], acc_q} + {term_ext[ACC_W-1], term_ext};
    // The extra bit holds the true sign; disagreement with the ACC_W sign bit means overflow.
    assign sum_ovf  = sum[ACC_W] ^ sum[ACC_W-1];

`ifdef MAC_SEQ_SATURATE_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    assign next_acc = !sum_ovf ? sum[ACC_W-1:0] : (sum[ACC_W] ? SAT_MIN : SAT_MAX);
`else
    assign next_acc = sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        ovf_d         = ovf_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_d   = bus.len;
                    acc_d   = bus.init_val;
                    ovf_d   = 1'b0;
                    state_d = (bus.len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    acc_d = next_acc;
                    cnt_d = cnt_q - 1'b1;
                    ovf_d = ovf_q | sum_ovf;
                    if (cnt_q == CNT_W'(1)) state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.out_data = acc_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_mac_acc_sequencer.sv
// Randomised and directed checks of mac_acc_sequencer against an integer-arithmetic job model.
module tb_mac_acc_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_acc_sequencer_if #(.ACC_W(32), .IN_W(16), .CNT_W(8)) bus ();
    mac_acc_sequencer #(.ACC_W(32), .IN_W(16), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int errs = 0;
    int checks = 0;
    int terms [0:255];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Whole-job result computed with 64-bit integers and range tests.
    task automatic ref_job(input logic [31:0] init, input int n,
                           output logic [31:0] res, output logic o);
        longint acc;
        logic [31:0] lo;
        acc = longint'($signed(init));
        o = 1'b0;
        for (int i = 0; i < n; i++) begin
            acc = acc + longint'(terms[i]);
            if (acc > 64'sd2147483647 || acc < -64'sd2147483648) begin
                o = 1'b1;
`ifdef MAC_SEQ_SATURATE_EN
                acc = (acc > 0) ? 64'sd2147483647 : -64'sd2147483648;
`endif
            end
            lo = acc[31:0];
            acc = longint'($signed(lo));
        end
        res = acc[31:0];
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(); step();
        checks++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'd0) begin errs++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
        checks++; if (bus.busy !== 1'b0 || bus.ovf !== 1'b0) begin errs++; $display("FAIL reset_busy_ovf got=%b%b exp=00", bus.busy, bus.ovf); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        bus.start = 1'b1; bus.len = 8'd4; bus.init_val = 32'd10;
        step();
        bus.start = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL basic_start_latency in_ready=%b exp=1", bus.in_ready); end
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 16'(i);
            step();
            if (i == 3) begin
                checks++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL basic_early_valid got=%b exp=0", bus.out_valid); end
            end
        end
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL basic_out_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_data !== 32'd20) begin errs++; $display("FAIL basic_out_data got=%0d exp=20", bus.out_data); end
        checks++; if (bus.ovf !== 1'b0 || bus.in_ready !== 1'b0) begin errs++; $display("FAIL basic_ovf_ready got=%b%b exp=00", bus.ovf, bus.in_ready); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL basic_busy_after_hs got=%b exp=0", bus.busy); end
    endtask

    task automatic test_zero_len();
        bus.start = 1'b1; bus.len = 8'd0; bus.init_val = -32'sd5;
        step();
        bus.start = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL zero_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL zero_out_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_data !== 32'hFFFF_FFFB) begin errs++; $display("FAIL zero_out_data got=%h exp=fffffffb", bus.out_data); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_stalls();
        logic [15:0] st [0:2];
        logic [31:0] acc_exp;
        st[0] = 16'd5; st[1] = -16'sd2; st[2] = 16'd7;
        acc_exp = 32'd0;
        bus.start = 1'b1; bus.len = 8'd3; bus.init_val = 32'd0;
        step();
        for (int i = 0; i < 3; i++) begin
            for (int g = 0; g < 2; g++) begin
                bus.in_valid = 1'b0;
                bus.start = (i == 1 && g == 0);
                bus.len = 8'd9; bus.init_val = 32'h1234_5678;
                step();
                checks++; if (bus.out_data !== acc_exp || bus.in_ready !== 1'b1) begin errs++; $display("FAIL stall_gap_hold got=%h/%b exp=%h/1", bus.out_data, bus.in_ready, acc_exp); end
            end
            bus.start = 1'b0;
            bus.in_valid = 1'b1; bus.in_data = st[i];
            step();
            acc_exp = acc_exp + {{16{st[i][15]}}, st[i]};
        end
        bus.in_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
            bus.start = (s == 1);
            step();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd10) begin errs++; $display("FAIL stall_backpressure got=%b/%0d exp=1/10", bus.out_valid, bus.out_data); end
        end
        bus.start = 1'b1; bus.len = 8'd0;
        bus.out_ready = 1'b1;
        step();
        bus.start = 1'b0; bus.out_ready = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errs++; $display("FAIL stall_start_at_hs got=%b%b exp=00", bus.busy, bus.out_valid); end
        step();
        checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL stall_idle_stays got=%b exp=0", bus.busy); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_d;
`ifdef MAC_SEQ_SATURATE_EN
        exp_d = 32'h7FFF_FFFF;
`else
        exp_d = 32'h8000_7FEF;
`endif
        bus.start = 1'b1; bus.len = 8'd1; bus.init_val = 32'h7FFF_FFF0;
        step();
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 16'h7FFF;
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_data !== exp_d) begin errs++; $display("FAIL ovf_out_data got=%h exp=%h", bus.out_data, exp_d); end
        checks++; if (bus.ovf !== 1'b1) begin errs++; $display("FAIL ovf_flag got=%b exp=1", bus.ovf); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        checks++; if (bus.ovf !== 1'b1) begin errs++; $display("FAIL ovf_sticky_idle got=%b exp=1", bus.ovf); end
        bus.start = 1'b1; bus.len = 8'd0; bus.init_val = 32'd1;
        step();
        bus.start = 1'b0;
        checks++; if (bus.ovf !== 1'b0) begin errs++; $display("FAIL ovf_cleared got=%b exp=0", bus.ovf); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.start = 1'b1; bus.len = 8'd4; bus.init_val = 32'd100;
        step();
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 16'd3;
        step(); step();
        reset = 1'b0;
        step();
        checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.ovf !== 1'b0) begin errs++; $display("FAIL rstmid_ctrl got=%b%b%b%b exp=0000", bus.in_ready, bus.out_valid, bus.busy, bus.ovf); end
        checks++; if (bus.out_data !== 32'd0) begin errs++; $display("FAIL rstmid_data got=%h exp=0", bus.out_data); end
        reset = 1'b1; bus.in_valid = 1'b0;
        step();
        bus.start = 1'b1; bus.len = 8'd1; bus.init_val = 32'd0;
        step();
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 16'd7;
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd7) begin errs++; $display("FAIL rstmid_newjob got=%b/%0d exp=1/7", bus.out_valid, bus.out_data); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] iv;
        bus.start = 1'b1; bus.len = 8'd2;
        bus.in_valid = 1'b1; bus.in_data = 16'd1; bus.out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            iv = $urandom;
            bus.init_val = iv;
            step(); step(); step();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== iv + 32'd2) begin errs++; $display("FAIL b2b_result job=%0d got=%b/%h exp=1/%h", j, bus.out_valid, bus.out_data, iv + 32'd2); end
            step();
            checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL b2b_period job=%0d busy=%b exp=0", j, bus.busy); end
        end
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [31:0] init, res, hold;
        logic o;
        int n;
        for (int j = 0; j < 12; j++) begin
            n = $urandom_range(0, 10);
            case (j % 3)
                0: init = $urandom;
                1: init = 32'h7FFF_0000 + $urandom_range(0, 65535);
                default: init = 32'h8000_FFFF - $urandom_range(0, 65535);
            endcase
            for (int i = 0; i < n; i++) terms[i] = $signed(16'($urandom));
            ref_job(init, n, res, o);
            bus.start = 1'b1; bus.len = 8'(n); bus.init_val = init;
            step();
            bus.start = 1'b0;
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.in_valid = 1'b0;
                    step();
                end
                checks++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL rnd_in_ready job=%0d beat=%0d got=%b exp=1", j, i, bus.in_ready); end
                bus.in_valid = 1'b1; bus.in_data = terms[i][15:0];
                step();
            end
            bus.in_valid = 1'b0;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== res) begin errs++; $display("FAIL rnd_result job=%0d got=%b/%h exp=1/%h", j, bus.out_valid, bus.out_data, res); end
            checks++; if (bus.ovf !== o) begin errs++; $display("FAIL rnd_ovf job=%0d got=%b exp=%b", j, bus.ovf, o); end
            hold = bus.out_data;
            repeat ($urandom_range(0, 2)) begin
                step();
                checks++; if (bus.out_data !== res || bus.out_valid !== 1'b1) begin errs++; $display("FAIL rnd_hold job=%0d got=%h exp=%h", j, bus.out_data, hold); end
            end
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
            checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rnd_idle job=%0d busy=%b exp=0", j, bus.busy); end
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.start = 1'b0; bus.len = '0; bus.init_val = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_zero_len();
        test_stalls();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
